// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch (F stage) and data access (M stage) requesters. Handles one
//   transaction at a time: IDLE (arbitrate) -> ISSUE (MemReq strobe) ->
//   WAIT (MEM_LAT cycles) -> RESP (one-cycle Ready pulse to the owner).
//   When both requesters ask at once, data wins unless it won last time.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   IReqF/IAddrF        fetch request (held until IReadyF) and address
//   IRdataF/IReadyF     registered fetch data and completion pulse
//   DReqM/DWeM/DAddrM   data request, store select, address
//   DWdataM             store data
//   DRdataM/DReadyM     registered load data and completion pulse
//   MemReq/MemWe        memory command strobe and qualified write enable
//   MemAddr/MemWdata    memory command address / write data
//   MemRdata            memory read data, valid MEM_LAT cycles after MemReq
//   StallF/StallM       requester waiting (request high, no Ready this cycle)
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IReadyF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DReadyM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              StallF,
  output logic              StallM
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_d;
  logic [3:0]          r_cnt;
  logic                r_own_d;
  logic                r_cmd_we;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic                r_iready;
  logic                r_dready;
  logic [DATA_W-1:0]   r_irdata;
  logic [DATA_W-1:0]   r_drdata;

  logic                w_grant;
  logic                w_grant_d;
  logic                w_cnt_zero;

  // Arbitration: data wins a tie unless it also won the previous grant.
  always_comb begin
    w_grant    = (r_state == S_IDLE) & (IReqF | DReqM);
    w_grant_d  = DReqM & (~IReqF | ~r_last_d);
    w_cnt_zero = (r_cnt == 4'd0);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_cnt_zero) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command latch at grant, wait counter, response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d    <= 1'b0;
      r_cnt       <= 4'd0;
      r_own_d     <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_iready    <= 1'b0;
      r_dready    <= 1'b0;
      r_irdata    <= '0;
      r_drdata    <= '0;
    end else begin
      r_iready <= 1'b0;
      r_dready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_own_d     <= w_grant_d;
            r_last_d    <= w_grant_d;
            r_cmd_we    <= w_grant_d & DWeM;
            r_cmd_addr  <= w_grant_d ? DAddrM : IAddrF;
            // A fetch carries no write data.
            r_cmd_wdata <= w_grant_d ? DWdataM : '0;
          end
        end
        S_ISSUE: begin
          r_cnt <= LAT_M1;
        end
        S_WAIT: begin
          if (w_cnt_zero) begin
            if (r_own_d) begin
              r_dready <= 1'b1;
              // A store leaves the load data register untouched.
              if (!r_cmd_we) r_drdata <= MemRdata;
            end else begin
              r_iready <= 1'b1;
              r_irdata <= MemRdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory command: strobe only in ISSUE; address/data hold between commands.
  always_comb begin
    MemReq   = (r_state == S_ISSUE);
    MemWe    = (r_state == S_ISSUE) & r_cmd_we;
    MemAddr  = r_cmd_addr;
    MemWdata = r_cmd_wdata;
    IRdataF  = r_irdata;
    IReadyF  = r_iready;
    DRdataM  = r_drdata;
    DReadyM  = r_dready;
    StallF   = IReqF & ~r_iready;
    StallM   = DReqM & ~r_dready;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int N = 3;

  localparam logic [31:0] AI = 32'h0000_0044;
  localparam logic [31:0] AD = 32'h0000_0100;
  localparam logic [31:0] AF = 32'h0000_0040;
  localparam logic [31:0] AS = 32'h0000_0200;
  localparam logic [31:0] WS = 32'hDEAD_BEEF;
  localparam logic [31:0] X1 = 32'h8C09_0004;
  localparam logic [31:0] X2 = 32'h1234_5678;
  localparam logic [31:0] X3 = 32'h2008_0005;
  localparam logic [31:0] Z  = 32'h0;

  // Instance 0: MEM_LAT=2, instance 1: MEM_LAT=1, instance 2: MEM_LAT=5.
  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 5;
  endfunction

  // Power-up memory contents (word index = addr[9:2]).
  function automatic logic [31:0] init_word(input int i);
    case (i)
      16:      return X3;
      17:      return X1;
      64:      return X2;
      default: return {8'(i), 8'(~i), 8'(i * 3), 8'hA5};
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        ireq   [N];
  logic [31:0] iaddr  [N];
  logic        dreq   [N];
  logic        dwe    [N];
  logic [31:0] daddr  [N];
  logic [31:0] dwdata [N];
  logic [31:0] irdata [N];
  logic        iready [N];
  logic [31:0] drdata [N];
  logic        dready [N];
  logic        mreq   [N];
  logic        mwe    [N];
  logic [31:0] maddr  [N];
  logic [31:0] mwdata [N];
  logic [31:0] mrdata [N];
  logic        stallf [N];
  logic        stallm [N];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int L = lat_of(k);

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .IReqF    (ireq[k]),
      .IAddrF   (iaddr[k]),
      .IRdataF  (irdata[k]),
      .IReadyF  (iready[k]),
      .DReqM    (dreq[k]),
      .DWeM     (dwe[k]),
      .DAddrM   (daddr[k]),
      .DWdataM  (dwdata[k]),
      .DRdataM  (drdata[k]),
      .DReadyM  (dready[k]),
      .MemReq   (mreq[k]),
      .MemWe    (mwe[k]),
      .MemAddr  (maddr[k]),
      .MemWdata (mwdata[k]),
      .MemRdata (mrdata[k]),
      .StallF   (stallf[k]),
      .StallM   (stallm[k])
    );

    // Fixed-latency memory: read data appears exactly L cycles after the
    // MemReq cycle and only then; every other cycle returns junk.
    bit          wr [256];
    logic [31:0] wv [256];
    logic [31:0] pd [16];
    bit          pv [16];
    logic [7:0]  idx;
    assign idx = maddr[k][9:2];

    always @(posedge clk) begin
      for (int i = 0; i < 15; i++) begin
        pd[i] <= pd[i + 1];
        pv[i] <= pv[i + 1];
      end
      pv[15] <= 1'b0;
      if (mreq[k]) begin
        if (mwe[k]) begin
          wr[idx] <= 1'b1;
          wv[idx] <= mwdata[k];
        end else begin
          pv[L - 1] <= 1'b1;
          pd[L - 1] <= wr[idx] ? wv[idx] : init_word(int'(idx));
        end
      end
    end

    assign mrdata[k] = pv[0] ? pd[0] : (32'hBADC_0DE0 ^ 32'(k));
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      ireq[k] = 1'b0; iaddr[k] = Z; dreq[k] = 1'b0; dwe[k] = 1'b0;
      daddr[k] = Z; dwdata[k] = Z;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        memreq;
    logic        memwe;
    logic [31:0] memaddr;
    logic [31:0] memwdata;
    logic        iready;
    logic [31:0] irdata;
    logic        dready;
    logic [31:0] drdata;
    logic        stallf;
    logic        stallm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t row(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd, input logic mr, input logic mw,
                               input logic [31:0] ma, input logic [31:0] md, input logic iy, input logic [31:0] id,
                               input logic dy, input logic [31:0] dq, input logic sf, input logic sm);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dd;
    v.memreq = mr; v.memwe = mw; v.memaddr = ma; v.memwdata = md;
    v.iready = iy; v.irdata = id; v.dready = dy; v.drdata = dq; v.stallf = sf; v.stallm = sm;
    return v;
  endfunction

  // Reference model state (transaction timeline per instance).
  int          m_nxt  [N];
  int          m_g    [N];
  bit          m_act  [N];
  bit          m_own  [N];
  bit          m_we   [N];
  bit          m_lastd[N];
  logic [31:0] m_addr [N];
  logic [31:0] m_wd   [N];
  logic [31:0] m_data [N];
  logic [31:0] e_maddr[N];
  logic [31:0] e_ird  [N];
  logic [31:0] e_drd  [N];
  logic [31:0] shadow [N][16];
  bit          sv_ir  [N];
  bit          sv_dr  [N];

  // One cycle of the reference: a grant starts a timeline where the command
  // appears at g+1 and the response at g+L+2; next arbitration at g+L+3.
  task automatic model_step(input int k, input int t);
    int   lat;
    logic e_mreq, e_mwe, e_ir, e_dr;
    lat = lat_of(k);
    if (t >= m_nxt[k] && (ireq[k] || dreq[k])) begin
      m_own[k]   = dreq[k] && (!ireq[k] || !m_lastd[k]);
      m_lastd[k] = m_own[k];
      m_g[k]     = t;
      m_act[k]   = 1'b1;
      m_nxt[k]   = t + lat + 3;
      m_we[k]    = m_own[k] && dwe[k];
      m_addr[k]  = m_own[k] ? daddr[k] : iaddr[k];
      m_wd[k]    = dwdata[k];
      if (m_we[k]) shadow[k][m_addr[k][5:2]] = dwdata[k];
      m_data[k]  = shadow[k][m_addr[k][5:2]];
    end
    e_mreq = m_act[k] && (t == m_g[k] + 1);
    if (e_mreq) e_maddr[k] = m_addr[k];
    e_mwe = e_mreq && m_we[k];
    e_ir  = m_act[k] && !m_own[k] && (t == m_g[k] + lat + 2);
    e_dr  = m_act[k] && m_own[k] && (t == m_g[k] + lat + 2);
    if (e_ir) e_ird[k] = m_data[k];
    if (e_dr && !m_we[k]) e_drd[k] = m_data[k];

    chk($sformatf("rnd%0d t%0d MemReq", k, t), 32'(mreq[k]), 32'(e_mreq));
    chk($sformatf("rnd%0d t%0d MemWe", k, t), 32'(mwe[k]), 32'(e_mwe));
    chk($sformatf("rnd%0d t%0d MemAddr", k, t), maddr[k], e_maddr[k]);
    if (e_mwe) chk($sformatf("rnd%0d t%0d MemWdata", k, t), mwdata[k], m_wd[k]);
    chk($sformatf("rnd%0d t%0d IReadyF", k, t), 32'(iready[k]), 32'(e_ir));
    chk($sformatf("rnd%0d t%0d DReadyM", k, t), 32'(dready[k]), 32'(e_dr));
    chk($sformatf("rnd%0d t%0d IRdataF", k, t), irdata[k], e_ird[k]);
    chk($sformatf("rnd%0d t%0d DRdataM", k, t), drdata[k], e_drd[k]);
    chk($sformatf("rnd%0d t%0d StallF", k, t), 32'(stallf[k]), 32'(ireq[k] && !e_ir));
    chk($sformatf("rnd%0d t%0d StallM", k, t), 32'(stallm[k]), 32'(dreq[k] && !e_dr));
  endtask

  function automatic logic [31:0] raddr();
    return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    logic [31:0] order[$];
    int lat;

    // Reset values on every instance.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst%0d MemReq", k), 32'(mreq[k]), Z);
      chk($sformatf("rst%0d MemWe", k), 32'(mwe[k]), Z);
      chk($sformatf("rst%0d MemAddr", k), maddr[k], Z);
      chk($sformatf("rst%0d MemWdata", k), mwdata[k], Z);
      chk($sformatf("rst%0d IReadyF", k), 32'(iready[k]), Z);
      chk($sformatf("rst%0d DReadyM", k), 32'(dready[k]), Z);
      chk($sformatf("rst%0d IRdataF", k), irdata[k], Z);
      chk($sformatf("rst%0d DRdataM", k), drdata[k], Z);
    end
    @(posedge clk);
    #1;

    // Table: simultaneous fetch+load from reset, fetch alone, store (MEM_LAT=2).
    tv.push_back(row(1'b1, AI, 1'b1, 1'b0, AD, Z, 1'b0, 1'b0, Z,  Z,  1'b0, Z,  1'b0, Z,  1'b1, 1'b1));
    tv.push_back(row(1'b1, AI, 1'b1, 1'b0, AD, Z, 1'b1, 1'b0, AD, Z,  1'b0, Z,  1'b0, Z,  1'b1, 1'b1));
    tv.push_back(row(1'b1, AI, 1'b1, 1'b0, AD, Z, 1'b0, 1'b0, AD, Z,  1'b0, Z,  1'b0, Z,  1'b1, 1'b1));
    tv.push_back(row(1'b1, AI, 1'b1, 1'b0, AD, Z, 1'b0, 1'b0, AD, Z,  1'b0, Z,  1'b0, Z,  1'b1, 1'b1));
    tv.push_back(row(1'b1, AI, 1'b1, 1'b0, AD, Z, 1'b0, 1'b0, AD, Z,  1'b0, Z,  1'b1, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AI, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AD, Z,  1'b0, Z,  1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AI, 1'b0, 1'b0, Z,  Z, 1'b1, 1'b0, AI, Z,  1'b0, Z,  1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AI, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AI, Z,  1'b0, Z,  1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AI, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AI, Z,  1'b0, Z,  1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AI, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AI, Z,  1'b1, X1, 1'b0, X2, 1'b0, 1'b0));
    tv.push_back(row(1'b1, AF, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AI, Z,  1'b0, X1, 1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AF, 1'b0, 1'b0, Z,  Z, 1'b1, 1'b0, AF, Z,  1'b0, X1, 1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AF, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AF, Z,  1'b0, X1, 1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AF, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AF, Z,  1'b0, X1, 1'b0, X2, 1'b1, 1'b0));
    tv.push_back(row(1'b1, AF, 1'b0, 1'b0, Z,  Z, 1'b0, 1'b0, AF, Z,  1'b1, X3, 1'b0, X2, 1'b0, 1'b0));
    tv.push_back(row(1'b0, Z,  1'b1, 1'b1, AS, WS, 1'b0, 1'b0, AF, Z,  1'b0, X3, 1'b0, X2, 1'b0, 1'b1));
    tv.push_back(row(1'b0, Z,  1'b1, 1'b1, AS, WS, 1'b1, 1'b1, AS, WS, 1'b0, X3, 1'b0, X2, 1'b0, 1'b1));
    tv.push_back(row(1'b0, Z,  1'b1, 1'b1, AS, WS, 1'b0, 1'b0, AS, WS, 1'b0, X3, 1'b0, X2, 1'b0, 1'b1));
    tv.push_back(row(1'b0, Z,  1'b1, 1'b1, AS, WS, 1'b0, 1'b0, AS, WS, 1'b0, X3, 1'b0, X2, 1'b0, 1'b1));
    tv.push_back(row(1'b0, Z,  1'b1, 1'b1, AS, WS, 1'b0, 1'b0, AS, WS, 1'b0, X3, 1'b1, X2, 1'b0, 1'b0));
    tv.push_back(row(1'b0, Z,  1'b0, 1'b0, Z,  Z,  1'b0, 1'b0, AS, WS, 1'b0, X3, 1'b0, X2, 1'b0, 1'b0));

    for (int i = 0; i < tv.size(); i++) begin
      ireq[0] = tv[i].ireq; iaddr[0] = tv[i].iaddr; dreq[0] = tv[i].dreq;
      dwe[0] = tv[i].dwe; daddr[0] = tv[i].daddr; dwdata[0] = tv[i].dwdata;
      @(negedge clk);
      chk($sformatf("tbl c%0d MemReq", i), 32'(mreq[0]), 32'(tv[i].memreq));
      chk($sformatf("tbl c%0d MemWe", i), 32'(mwe[0]), 32'(tv[i].memwe));
      chk($sformatf("tbl c%0d MemAddr", i), maddr[0], tv[i].memaddr);
      chk($sformatf("tbl c%0d MemWdata", i), mwdata[0], tv[i].memwdata);
      chk($sformatf("tbl c%0d IReadyF", i), 32'(iready[0]), 32'(tv[i].iready));
      chk($sformatf("tbl c%0d IRdataF", i), irdata[0], tv[i].irdata);
      chk($sformatf("tbl c%0d DReadyM", i), 32'(dready[0]), 32'(tv[i].dready));
      chk($sformatf("tbl c%0d DRdataM", i), drdata[0], tv[i].drdata);
      chk($sformatf("tbl c%0d StallF", i), 32'(stallf[0]), 32'(tv[i].stallf));
      chk($sformatf("tbl c%0d StallM", i), 32'(stallm[0]), 32'(tv[i].stallm));
      @(posedge clk);
      #1;
    end

    // Reset during WAIT of a load, then a fetch with normal latency.
    do_reset();
    dreq[0] = 1'b1; daddr[0] = AD;
    @(negedge clk);
    chk("midrst c0 StallM", 32'(stallm[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst c1 MemReq", 32'(mreq[0]), 32'd1);
    chk("midrst c1 MemAddr", maddr[0], AD);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst c2 MemReq", 32'(mreq[0]), Z);
    @(posedge clk); #1;
    rst = 1'b0; dreq[0] = 1'b0; daddr[0] = Z;
    for (int c = 3; c < 10; c++) begin
      if (c == 4) begin ireq[0] = 1'b1; iaddr[0] = AF; end
      @(negedge clk);
      chk($sformatf("midrst c%0d DReadyM", c), 32'(dready[0]), Z);
      chk($sformatf("midrst c%0d DRdataM", c), drdata[0], Z);
      chk($sformatf("midrst c%0d MemReq", c), 32'(mreq[0]), 32'(c == 5));
      chk($sformatf("midrst c%0d MemAddr", c), maddr[0], (c >= 5) ? AF : Z);
      chk($sformatf("midrst c%0d IReadyF", c), 32'(iready[0]), 32'(c == 8));
      chk($sformatf("midrst c%0d IRdataF", c), irdata[0], (c >= 8) ? X3 : Z);
      @(posedge clk); #1;
      if (c == 8) ireq[0] = 1'b0;
    end

    // Fairness: both held continuously -> D, I, D, I.
    do_reset();
    ireq[0] = 1'b1; iaddr[0] = AI; dreq[0] = 1'b1; daddr[0] = AD;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mreq[0]) order.push_back(maddr[0]);
      @(posedge clk); #1;
    end
    ireq[0] = 1'b0; dreq[0] = 1'b0;
    chk("fair count", 32'(order.size()), 32'd4);
    for (int j = 0; j < order.size(); j++)
      chk($sformatf("fair grant%0d", j), order[j], (j % 2 == 0) ? AD : AI);

    // Latency sweep on MEM_LAT=1 and MEM_LAT=5.
    do_reset();
    for (int k = 1; k < N; k++) begin ireq[k] = 1'b1; iaddr[k] = AF; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 1; k < N; k++) begin
        lat = lat_of(k);
        chk($sformatf("lat%0d c%0d MemReq", lat, c), 32'(mreq[k]), 32'(c == 1));
        chk($sformatf("lat%0d c%0d IReadyF", lat, c), 32'(iready[k]), 32'(c == lat + 2));
        if (c == lat + 2) chk($sformatf("lat%0d IRdataF", lat), irdata[k], X3);
      end
      @(posedge clk); #1;
      for (int k = 1; k < N; k++) if (c == lat_of(k) + 2) ireq[k] = 1'b0;
    end

    // Randomized traffic against the timeline model on all instances.
    do_reset();
    for (int k = 0; k < N; k++) begin
      m_nxt[k] = 0; m_g[k] = 0; m_act[k] = 1'b0; m_own[k] = 1'b0; m_we[k] = 1'b0;
      m_lastd[k] = 1'b0; m_addr[k] = Z; m_wd[k] = Z; m_data[k] = Z;
      e_maddr[k] = Z; e_ird[k] = Z; e_drd[k] = Z;
      for (int i = 0; i < 16; i++) shadow[k][i] = init_word(i);
    end
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        model_step(k, t);
        sv_ir[k] = iready[k];
        sv_dr[k] = dready[k];
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (ireq[k]) begin
          if (sv_ir[k]) begin
            if ($urandom_range(0, 1) == 1) iaddr[k] = raddr();
            else ireq[k] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) ireq[k] = 1'b0;
          else if ($urandom_range(0, 7) == 0) iaddr[k] = raddr();
        end else if ($urandom_range(0, 2) == 0) begin
          ireq[k] = 1'b1; iaddr[k] = raddr();
        end
        if (dreq[k]) begin
          if (sv_dr[k]) begin
            if ($urandom_range(0, 1) == 1) begin
              daddr[k] = raddr(); dwe[k] = 1'($urandom_range(0, 1)); dwdata[k] = $urandom;
            end else dreq[k] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) dreq[k] = 1'b0;
          else if ($urandom_range(0, 7) == 0) begin
            daddr[k] = raddr(); dwdata[k] = $urandom;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          dreq[k] = 1'b1; daddr[k] = raddr(); dwe[k] = 1'($urandom_range(0, 1)); dwdata[k] = $urandom;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
